// File: rtl/sevenseg_pkg.sv
// Shared types and the hex-to-segment decode table for the multi-digit display driver.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    // Active-low segments; bit 0 = a ... bit 6 = g.
    function automatic seg_t hex_to_seg(logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_lz_mask.sv
// Leading-zero blanking mask: a digit is blanked when it and every digit above it
// is a zero with no decimal point. Digit 0 is never blanked.
module sevenseg_lz_mask #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] nibbles,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   mask
);

    logic chain;

    // Walk from the most significant digit down; the first non-blank digit breaks the chain.
    always_comb begin
        mask  = '0;
        chain = blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            chain   = chain && (nibbles[4*i +: 4] == 4'h0) && !dp[i];
            mask[i] = chain;
        end
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Multi-digit hex display driver: shadowed value, registered static per-digit bus,
// and a time-multiplexed seg/anode pair with a blank interval at the start of each slot.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        load,
    input  logic [4*NUM_DIGITS-1:0]     value,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        blank_lz,
    output logic [7*NUM_DIGITS-1:0]     seg_all,
    output logic [NUM_DIGITS-1:0]       dp_all,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   dpv_q, dpv_d;
    logic                    valid_q, valid_d;
    logic [DIV_W-1:0]        psc_q, psc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7*NUM_DIGITS-1:0] seg_all_q, seg_all_d;
    logic [NUM_DIGITS-1:0]   dp_all_q, dp_all_d;
    seg_t                    seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [NUM_DIGITS-1:0]   lz_mask;
    seg_t [NUM_DIGITS-1:0]   dig_seg;
    logic [NUM_DIGITS-1:0]   dig_dp;

    sevenseg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
        .nibbles  (val_q),
        .dp       (dpv_q),
        .blank_lz (blank_lz),
        .mask     (lz_mask)
    );

    // Per-digit display codes, shared by the static and scanned outputs.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        assign dig_seg[i] = (valid_q && !lz_mask[i]) ? hex_to_seg(val_q[4*i +: 4]) : SEG_OFF;
        assign dig_dp[i]  = ~(valid_q & dpv_q[i]);
    end

    // Load is accepted regardless of enable so the shadow is always current.
    always_comb begin
        val_d   = val_q;
        dpv_d   = dpv_q;
        valid_d = valid_q;
        if (load) begin
            val_d   = value;
            dpv_d   = dp_in;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        psc_d     = '0;
        idx_d     = '0;
        seg_all_d = '1;
        dp_all_d  = '1;
        seg_d     = SEG_OFF;
        dp_d      = 1'b1;
        an_d      = '1;
        if (enable) begin
            seg_all_d = dig_seg;
            dp_all_d  = dig_dp;
            seg_d     = dig_seg[idx_q];
            dp_d      = dig_dp[idx_q];
            if (psc_q >= DIV_W'(BLANK_CYC))
                an_d[idx_q] = 1'b0;
            if (psc_q == DIV_W'(SCAN_DIV - 1)) begin
                psc_d = '0;
                idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
                idx_d = idx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q     <= '0;
            dpv_q     <= '0;
            valid_q   <= 1'b0;
            psc_q     <= '0;
            idx_q     <= '0;
            seg_all_q <= '1;
            dp_all_q  <= '1;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            an_q      <= '1;
        end else begin
            val_q     <= val_d;
            dpv_q     <= dpv_d;
            valid_q   <= valid_d;
            psc_q     <= psc_d;
            idx_q     <= idx_d;
            seg_all_q <= seg_all_d;
            dp_all_q  <= dp_all_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign seg_all   = seg_all_q;
    assign dp_all    = dp_all_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: a slot-arithmetic reference model queues the
// expected outputs for every edge and a separate monitor compares them after the edge.
module tb_sevenseg_scan;

    localparam int N     = 4;
    localparam int SDIV  = 8;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [27:0] seg_all;
    logic [3:0]  dp_all;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    sevenseg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SDIV), .BLANK_CYC(BLANK), .DIV_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg_all(seg_all), .dp_all(dp_all),
        .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] seg_all;
        logic [3:0]  dp_all;
        logic [6:0]  seg;
        logic        dp;
        logic [3:0]  an;
        logic [1:0]  idx;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: shadow contents and number of consecutive enabled edges.
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;
    logic        m_valid = 1'b0;
    int          m_t = 0;

    function automatic logic [6:0] ref_code(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tbl[n];
    endfunction

    // Digits above the most significant "meaningful" digit (nonzero or dp lit) are blank.
    function automatic logic [3:0] ref_supp(input logic [15:0] v, input logic [3:0] d, input logic bl);
        int top = 0;
        logic [3:0] m = '0;
        for (int i = 0; i < N; i++)
            if (v[i*4 +: 4] != 4'h0 || d[i]) top = i;
        if (bl)
            for (int i = 0; i < N; i++) if (i > top) m[i] = 1'b1;
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        logic [6:0] codes [N];
        logic [3:0] dps, sup;
        int ph, dg;
        if (!rst_n) begin
            m_val = '0; m_dp = '0; m_valid = 1'b0; m_t = 0;
        end else begin
            ph  = m_t % SDIV;
            dg  = (m_t / SDIV) % N;
            sup = ref_supp(m_val, m_dp, blank_lz);
            for (int i = 0; i < N; i++) begin
                codes[i] = (m_valid && !sup[i]) ? ref_code(m_val[i*4 +: 4]) : 7'h7F;
                dps[i]   = !(m_valid && m_dp[i]);
            end
            e.seg_all = '1; e.dp_all = '1; e.seg = 7'h7F; e.dp = 1'b1; e.an = '1;
            if (enable) begin
                for (int i = 0; i < N; i++) e.seg_all[i*7 +: 7] = codes[i];
                e.dp_all = dps;
                e.seg    = codes[dg];
                e.dp     = dps[dg];
                if (ph >= BLANK) e.an = ~(4'b0001 << dg);
                m_t++;
            end else begin
                m_t = 0;
            end
            e.idx = 2'((m_t / SDIV) % N);
            if (load) begin
                m_val = value; m_dp = dp_in; m_valid = 1'b1;
            end
            sbq.push_back(e);
        end
    end

    // Monitor: one queued expectation per edge, sampled 1 time unit after the edge.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if (seg_all !== e.seg_all || dp_all !== e.dp_all || seg !== e.seg ||
                dp !== e.dp || an !== e.an || digit_idx !== e.idx) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t: got seg_all=%b dp_all=%b seg=%b dp=%b an=%b idx=%0d, want seg_all=%b dp_all=%b seg=%b dp=%b an=%b idx=%0d",
                         $time, seg_all, dp_all, seg, dp, an, digit_idx,
                         e.seg_all, e.dp_all, e.seg, e.dp, e.an, e.idx);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Bounded wait until the model's scan position reaches (digit, prescaler).
    task automatic wait_pos(input int dg, input int ph, input string name);
        int n = 0;
        while (!(m_t % SDIV == ph && (m_t / SDIV) % N == dg) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            miscompares++;
            $display("FAIL %s: scan position digit %0d prescaler %0d not reached", name, dg, ph);
        end
    endtask

    initial begin
        repeat (3) tick();
        check("reset_seg_all", 64'(seg_all), 64'hFFFFFFF);
        check("reset_an", 64'(an), 64'hF);
        rst_n = 1'b1;
        repeat (2 * SDIV) tick();
        check("hold_idx", 64'(digit_idx), 64'd0);
        check("hold_seg_all", 64'(seg_all), 64'hFFFFFFF);

        // Static decode
        enable = 1'b1;
        do_load(16'h3A0F, 4'h0);
        tick();
        check("static_3A0F", 64'(seg_all), 64'(28'b0110000_0001000_1000000_0001110));
        check("static_dp", 64'(dp_all), 64'hF);

        // Leading-zero suppression and dp stopping it
        blank_lz = 1'b1;
        do_load(16'h0070, 4'h0);
        tick();
        check("lz_0070", 64'(seg_all), 64'(28'b1111111_1111111_1111000_1000000));
        do_load(16'h0070, 4'b0100);
        tick();
        check("lz_dp_seg", 64'(seg_all), 64'(28'b1111111_1000000_1111000_1000000));
        check("lz_dp_dp", 64'(dp_all), 64'b1011);

        // Scan timing over several full rounds
        blank_lz = 1'b0;
        do_load(16'h1234, 4'h0);
        repeat (3 * N * SDIV) tick();

        // Mid-slot load, then enable drop in digit 2, then re-enable
        wait_pos(1, 5, "midslot");
        do_load(16'hFFFF, 4'h0);
        tick();
        check("midslot_seg", 64'(seg), 64'b0001110);
        wait_pos(2, 4, "enable_drop");
        enable = 1'b0;
        tick();
        check("drop_an", 64'(an), 64'hF);
        check("drop_seg", 64'(seg), 64'h7F);
        repeat (5) tick();
        enable = 1'b1;
        tick();
        check("reenable_idx", 64'(digit_idx), 64'd0);
        check("reenable_blank_an", 64'(an), 64'hF);
        repeat (2 * SDIV) tick();

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            enable   = ($urandom_range(0, 19) != 0);
            blank_lz = 1'($urandom);
            value    = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            load     = ($urandom_range(0, 9) == 0);
            tick();
        end
        load = 1'b0;
        enable = 1'b1;

        // Async reset mid-scan during digit 3
        do_load(16'hBEEF, 4'h5);
        wait_pos(3, 3, "reset_wait");
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_seg_all", 64'(seg_all), 64'hFFFFFFF);
        check("async_an", 64'(an), 64'hF);
        check("async_seg", 64'({seg, dp}), 64'hFF);
        check("async_idx", 64'(digit_idx), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3 * SDIV) tick();
        check("post_reset_blank", 64'(seg_all), 64'hFFFFFFF);
        do_load(16'h0001, 4'h0);
        repeat (2 * SDIV) tick();

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
